i2c_master_nbyte: RTL and testbench

Parametrised I2C master replacing the fixed 16-bit controller. It runs single-master I2C write or read transactions of `NBYTES` data bytes with a programmable SCL rate. It reports slave NACKs and aborts on them, and gives a BUSY/DONE handshake to the host logic. It sits between the host register logic and the SDA/SCL pad wrappers.

---
 rtl/i2c_pkg.sv | 32 +++
 rtl/i2c_qtick_gen.sv | 50 +++++
 rtl/i2c_master_nbyte.sv | 211 +++++++++++++++++++++
 tb/tb_i2c_master_nbyte.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared definitions for the N-byte I2C master.
//   - i2c_state_t : transaction state encoding
//   - Q0..Q3      : quarter-phase codes within one SCL bit
//   - SCL_IDLE / SDA_IDLE : bus levels when nothing is happening
//   - NBYTES_* / CLK_DIV_MIN : legal parameter ranges
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    WDATA,
    WACK,
    RDATA,
    RACK,
    STOP
  } i2c_state_t;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic SCL_IDLE = 1'b1;
  localparam logic SDA_IDLE = 1'b1;

  localparam int NBYTES_MIN  = 1;
  localparam int NBYTES_MAX  = 8;
  localparam int CLK_DIV_MIN = 2;

endpackage

// File: rtl/i2c_qtick_gen.sv
// i2c_qtick_gen: quarter-period timebase for the I2C master.
//   clk     : clock
//   rst     : synchronous active-high reset
//   clear   : holds the timebase at the start of Q0 (asserted while idle)
//   q_tick  : high on the last cycle of each quarter
//   q_first : high on the first cycle of each quarter
//   phase   : current quarter (Q0..Q3)
module i2c_qtick_gen
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  output logic       q_tick,
  output logic       q_first,
  output logic [1:0] phase
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    phase_q, phase_d;

  // Divider wraps every CLK_DIV cycles and advances the phase on the wrap.
  always_comb begin
    q_tick  = (cnt_q == CW'(CLK_DIV - 1));
    q_first = (cnt_q == '0);
    cnt_d   = q_tick ? '0 : cnt_q + 1'b1;
    phase_d = q_tick ? phase_q + 2'd1 : phase_q;
    if (clear) begin
      cnt_d   = '0;
      phase_d = Q0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= Q0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/i2c_master_nbyte.sv
// i2c_master_nbyte: single-master I2C controller moving NBYTES data bytes
// per transaction, with slave-NACK abort and a BUSY/DONE host handshake.
//   CLK, RST          : clock, synchronous active-high reset
//   START_STB         : one-cycle request, honoured only when idle
//   RNW, I2C_ADDR     : direction and 7-bit slave address (latched on request)
//   WR_DATA           : write payload, most significant byte sent first
//   RD_DATA           : read payload, first received byte in the MSBs
//   BUSY, DONE        : transaction active / one-cycle end-of-transaction pulse
//   ACK_ERR           : sticky slave-NACK flag, cleared by the next request
//   SCL               : serial clock
//   SDA_OUT, SDA_OE   : SDA drive value and drive enable
//   SDA_IN            : sampled SDA line
module i2c_master_nbyte
  import i2c_pkg::*;
#(
  parameter int NBYTES  = 2,
  parameter int CLK_DIV = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START_STB,
  input  logic                RNW,
  input  logic [6:0]          I2C_ADDR,
  input  logic [8*NBYTES-1:0] WR_DATA,
  output logic [8*NBYTES-1:0] RD_DATA,
  output logic                BUSY,
  output logic                DONE,
  output logic                ACK_ERR,
  output logic                SCL,
  output logic                SDA_OUT,
  output logic                SDA_OE,
  input  logic                SDA_IN
);

  localparam int DW = 8 * NBYTES;
  localparam int BW = $clog2(NBYTES + 1);

  if (NBYTES < NBYTES_MIN || NBYTES > NBYTES_MAX || CLK_DIV < CLK_DIV_MIN) begin : g_bad_params
    $error("i2c_master_nbyte: NBYTES or CLK_DIV out of range");
  end

  i2c_state_t    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]    tx_q, tx_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rx_q, rx_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          ack_err_q, ack_err_d;
  logic          ack_q, ack_d;
  logic          rnw_q, rnw_d;

  logic          q_tick, q_first;
  logic [1:0]    phase;
  logic          bit_end, sample;

  i2c_qtick_gen #(.CLK_DIV(CLK_DIV)) u_qtick (
    .clk     (CLK),
    .rst     (RST),
    .clear   (state_q == IDLE),
    .q_tick  (q_tick),
    .q_first (q_first),
    .phase   (phase)
  );

  assign bit_end = q_tick && (phase == Q3);
  assign sample  = q_first && (phase == Q3);

  // Next-state, datapath and bus outputs. State and shift registers only
  // move at a bit boundary, so SDA naturally changes at the start of Q0.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    tx_d       = tx_q;
    wdata_d    = wdata_q;
    rx_d       = rx_q;
    rd_data_d  = rd_data_q;
    ack_err_d  = ack_err_q;
    ack_d      = ack_q;
    rnw_d      = rnw_q;
    SCL        = SCL_IDLE;
    SDA_OUT    = SDA_IDLE;
    SDA_OE     = 1'b0;
    DONE       = 1'b0;

    case (state_q)
      IDLE: begin
        if (START_STB) begin
          state_d    = START;
          rnw_d      = RNW;
          tx_d       = {I2C_ADDR, RNW};
          wdata_d    = WR_DATA;
          rx_d       = '0;
          ack_err_d  = 1'b0;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
        end
      end

      START: begin
        SCL     = 1'b1;
        SDA_OE  = 1'b1;
        SDA_OUT = (phase == Q0) || (phase == Q1);
        if (bit_end) state_d = ADDR;
      end

      ADDR, WDATA: begin
        SCL     = phase[1];
        SDA_OE  = 1'b1;
        SDA_OUT = tx_q[7];
        if (bit_end) begin
          tx_d      = {tx_q[6:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (state_q == ADDR) begin
              state_d = ADDR_ACK;
            end else begin
              state_d    = WACK;
              byte_cnt_d = byte_cnt_q + BW'(1);
            end
          end
        end
      end

      ADDR_ACK, WACK: begin
        SCL = phase[1];
        if (sample) ack_d = SDA_IN;
        if (bit_end) begin
          if (ack_q) begin
            ack_err_d = 1'b1;
            state_d   = STOP;
          end else if (state_q == ADDR_ACK && rnw_q) begin
            state_d = RDATA;
          end else if (state_q == WACK && byte_cnt_q == BW'(NBYTES)) begin
            state_d = STOP;
          end else begin
            state_d = WDATA;
            tx_d    = wdata_q[DW-1 -: 8];
            wdata_d = wdata_q << 8;
          end
        end
      end

      RDATA: begin
        SCL = phase[1];
        if (sample) rx_d = {rx_q[DW-2:0], SDA_IN};
        if (bit_end) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d    = RACK;
            byte_cnt_d = byte_cnt_q + BW'(1);
          end
        end
      end

      RACK: begin
        // ACK every byte except the last, which is NACKed to end the read.
        SCL     = phase[1];
        SDA_OE  = 1'b1;
        SDA_OUT = (byte_cnt_q == BW'(NBYTES));
        if (bit_end) state_d = (byte_cnt_q == BW'(NBYTES)) ? STOP : RDATA;
      end

      STOP: begin
        SCL     = (phase != Q0);
        SDA_OE  = ~phase[1];
        SDA_OUT = phase[1];
        if (bit_end) begin
          DONE    = 1'b1;
          state_d = IDLE;
          if (rnw_q && !ack_err_q) rd_data_d = rx_q;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // BUSY drops on the DONE cycle so the host sees both edges together.
  assign BUSY    = (state_q != IDLE) && !DONE;
  assign ACK_ERR = ack_err_q;
  assign RD_DATA = rd_data_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      tx_q       <= '0;
      wdata_q    <= '0;
      rx_q       <= '0;
      rd_data_q  <= '0;
      ack_err_q  <= 1'b0;
      ack_q      <= 1'b0;
      rnw_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      tx_q       <= tx_d;
      wdata_q    <= wdata_d;
      rx_q       <= rx_d;
      rd_data_q  <= rd_data_d;
      ack_err_q  <= ack_err_d;
      ack_q      <= ack_d;
      rnw_q      <= rnw_d;
    end
  end

endmodule

// File: tb/tb_i2c_master_nbyte.sv
// tb_i2c_master_nbyte: directed bench for i2c_master_nbyte. One instance
// with default parameters and one with NBYTES=1, CLK_DIV=2; a simple slave
// model drives SDA_IN per bit slot and the master's bits are captured mid-SCL-high.
module tb_i2c_master_nbyte;

  typedef struct {
    logic        rnw;
    logic [6:0]  addr;
    logic [15:0] wdata;
    logic [15:0] slave_rd;
    int          nack_at;
    int          exp_done;
    logic [7:0]  exp_addr;
    logic        exp_err;
    logic [15:0] exp_rd;
    int          nchk;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic        rnw = 1'b0;
  logic [6:0]  addr = '0;
  logic [15:0] wdata = '0;
  logic        sda_in = 1'b1;
  logic        sel = 1'b0;

  logic [15:0] rd0;
  logic [7:0]  rd1;
  logic        busy0, done0, err0, scl0, so0, oe0;
  logic        busy1, done1, err1, scl1, so1, oe1;

  logic        m_busy, m_done, m_err, m_scl, m_so, m_oe;
  logic [15:0] m_rd;

  int          tests = 0;
  int          failed = 0;
  logic        slave_bits [64];
  logic        master_bits[64];
  logic        oe_bits    [64];
  int          done_cyc;
  int          scl_high;
  logic        final_busy, final_done, final_err;
  logic [15:0] final_rd;
  vec_t        vecs[6];
  vec_t        v;

  always #5 clock = ~clock;

  i2c_master_nbyte #(.NBYTES(2), .CLK_DIV(4)) dut (
    .CLK(clock), .RST(reset), .START_STB(start0), .RNW(rnw), .I2C_ADDR(addr),
    .WR_DATA(wdata), .RD_DATA(rd0), .BUSY(busy0), .DONE(done0), .ACK_ERR(err0),
    .SCL(scl0), .SDA_OUT(so0), .SDA_OE(oe0), .SDA_IN(sda_in)
  );

  i2c_master_nbyte #(.NBYTES(1), .CLK_DIV(2)) dut1 (
    .CLK(clock), .RST(reset), .START_STB(start1), .RNW(rnw), .I2C_ADDR(addr),
    .WR_DATA(wdata[7:0]), .RD_DATA(rd1), .BUSY(busy1), .DONE(done1), .ACK_ERR(err1),
    .SCL(scl1), .SDA_OUT(so1), .SDA_OE(oe1), .SDA_IN(sda_in)
  );

  assign m_busy = sel ? busy1 : busy0;
  assign m_done = sel ? done1 : done0;
  assign m_err  = sel ? err1  : err0;
  assign m_scl  = sel ? scl1  : scl0;
  assign m_so   = sel ? so1   : so0;
  assign m_oe   = sel ? oe1   : oe0;
  assign m_rd   = sel ? {8'h00, rd1} : rd0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] getByte(input int first);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = master_bits[first+i];
    return r;
  endfunction

  // Bus outputs and status at their reset/idle values.
  task automatic checkIdle(input string tag);
    checkOutput({tag, "_scl"},    m_scl,  1'b1);
    checkOutput({tag, "_sda_oe"}, m_oe,   1'b0);
    checkOutput({tag, "_sda_out"},m_so,   1'b1);
    checkOutput({tag, "_busy"},   m_busy, 1'b0);
    checkOutput({tag, "_done"},   m_done, 1'b0);
    checkOutput({tag, "_ack_err"},m_err,  1'b0);
    checkOutput({tag, "_rd_data"},m_rd,   16'h0000);
  endtask

  // Runs one transaction cycle by cycle. Cycle 0 is the START_STB cycle.
  task automatic applyStimulus(input logic s, input vec_t tv, input int stb_at,
                               input logic stb_on_done, input int rst_at);
    int bitlen, nb, b, off;
    bitlen = s ? 8 : 16;
    nb     = s ? 1 : 2;
    sel    = s;
    for (int i = 0; i < 64; i++) begin
      slave_bits[i]  = 1'b1;
      master_bits[i] = 1'bx;
      oe_bits[i]     = 1'bx;
    end
    for (int k = 0; k <= nb; k++) slave_bits[9+9*k] = (tv.nack_at == k);
    if (tv.rnw)
      for (int k = 1; k <= nb; k++)
        for (int i = 0; i < 8; i++) slave_bits[9*k+1+i] = tv.slave_rd[15-8*(k-1)-i];

    @(negedge clock);
    rnw = tv.rnw; addr = tv.addr; wdata = tv.wdata;
    if (s) start1 = 1'b1; else start0 = 1'b1;
    done_cyc = -1;
    scl_high = 0;
    for (int c = 1; c <= 2000 && done_cyc < 0; c++) begin
      @(negedge clock);
      start0 = 1'b0; start1 = 1'b0;
      b   = (c - 1) / bitlen;
      off = (c - 1) % bitlen;
      if (b < 64) sda_in = slave_bits[b];
      if (c == 1) begin
        checkOutput("busy_at_cycle1", m_busy, 1'b1);
        checkOutput("ack_err_cleared", m_err, 1'b0);
      end
      if (c == rst_at + 1) begin
        reset = 1'b0;
        sda_in = 1'b1;
        checkIdle("mid_reset");
        return;
      end
      if (c == rst_at) reset = 1'b1;
      if (c == stb_at) begin
        addr = 7'h7F; wdata = 16'hFFFF; rnw = ~tv.rnw;
        if (s) start1 = 1'b1; else start0 = 1'b1;
      end
      if (off == bitlen / 2 && b < 64) begin
        master_bits[b] = m_so;
        oe_bits[b]     = m_oe;
      end
      if (b == 1 && m_scl) scl_high++;
      if (m_done) begin
        done_cyc = c;
        if (stb_on_done) begin
          if (s) start1 = 1'b1; else start0 = 1'b1;
        end
      end
    end
    if (done_cyc < 0) checkOutput("done_timeout", 1'b0, 1'b1);
    @(negedge clock);
    start0 = 1'b0; start1 = 1'b0;
    sda_in = 1'b1;
    final_busy = m_busy;
    final_done = m_done;
    final_err  = m_err;
    final_rd   = m_rd;
  endtask

  task automatic checkTxn(input logic s, input vec_t tv);
    int nb;
    nb = s ? 1 : 2;
    checkOutput("done_cycle",  done_cyc, tv.exp_done);
    checkOutput("addr_byte",   getByte(1), tv.exp_addr);
    checkOutput("addr_ack_oe", oe_bits[9], 1'b0);
    checkOutput("scl_high",    scl_high, s ? 4 : 8);
    checkOutput("ack_err",     final_err, tv.exp_err);
    checkOutput("rd_data",     final_rd, tv.exp_rd);
    checkOutput("busy_after",  final_busy, 1'b0);
    checkOutput("done_after",  final_done, 1'b0);
    for (int k = 1; k <= tv.nchk; k++)
      checkOutput("wr_byte", getByte(9*k+1), 8'((tv.wdata >> (8*(nb-k))) & 16'h00FF));
    if (tv.rnw && !tv.exp_err)
      for (int k = 1; k <= nb; k++) begin
        checkOutput("rack_bit", master_bits[9+9*k], (k == nb));
        checkOutput("rack_oe",  oe_bits[9+9*k], 1'b1);
      end
  endtask

  initial begin
    vecs[0] = '{1'b0, 7'h2A, 16'hA55A, 16'h0000, -1, 464, 8'h54, 1'b0, 16'h0000, 2};
    vecs[1] = '{1'b1, 7'h50, 16'h0000, 16'h1234, -1, 464, 8'hA1, 1'b0, 16'h1234, 0};
    vecs[2] = '{1'b0, 7'h33, 16'h1111, 16'h0000,  0, 176, 8'h66, 1'b1, 16'h1234, 0};
    vecs[3] = '{1'b0, 7'h11, 16'hC3F0, 16'h0000,  1, 320, 8'h22, 1'b1, 16'h1234, 1};
    vecs[4] = '{1'b1, 7'h7F, 16'h0000, 16'hABCD,  0, 176, 8'hFF, 1'b1, 16'h1234, 0};
    vecs[5] = '{1'b1, 7'h01, 16'h0000, 16'hFF00, -1, 464, 8'h03, 1'b0, 16'hFF00, 0};

    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    sel = 1'b0;
    checkIdle("reset");

    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, vecs[i], -1, 1'b0, -10);
      checkTxn(1'b0, vecs[i]);
      repeat (3) @(negedge clock);
    end

    // Stray request mid-transaction and on the DONE cycle are both ignored.
    v = vecs[0];
    v.exp_rd = 16'hFF00;
    applyStimulus(1'b0, v, 50, 1'b1, -10);
    checkTxn(1'b0, v);
    @(negedge clock);
    checkOutput("stb_on_done_busy", m_busy, 1'b0);
    repeat (2) @(negedge clock);

    // Reset in the middle of a read, then a clean write.
    applyStimulus(1'b0, vecs[1], -1, 1'b0, 100);
    repeat (2) @(negedge clock);
    v = vecs[0];
    applyStimulus(1'b0, v, -1, 1'b0, -10);
    checkTxn(1'b0, v);
    repeat (3) @(negedge clock);

    // Minimal configuration: one byte, fastest SCL.
    v = '{1'b0, 7'h2A, 16'h003C, 16'h0000, -1, 160, 8'h54, 1'b0, 16'h0000, 1};
    applyStimulus(1'b1, v, -1, 1'b0, -10);
    checkTxn(1'b1, v);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
